fu_issue_ctrl: RTL and testbench



---
 rtl/fu_issue_ctrl.sv | 114 +++++++++++
 tb/tb_fu_issue_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: single-register issue stage driving the FU operand bundle and one per-unit strobe
module fu_issue_ctrl #(
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ack_o,
    input  logic [2:0]               issue_fu_i,
    input  logic [7:0]               issue_op_i,
    input  logic [XLEN-1:0]          issue_operand_a_i,
    input  logic [XLEN-1:0]          issue_operand_b_i,
    input  logic [XLEN-1:0]          issue_imm_i,
    input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
    input  logic                     flu_ready_i,
    input  logic                     lsu_ready_i,
    input  logic                     fpu_ready_i,
    input  logic                     resolve_branch_i,
    output logic [7:0]               fu_op_o,
    output logic [XLEN-1:0]          operand_a_o,
    output logic [XLEN-1:0]          operand_b_o,
    output logic [XLEN-1:0]          imm_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     alu_valid_o,
    output logic                     branch_valid_o,
    output logic                     csr_valid_o,
    output logic                     mult_valid_o,
    output logic                     lsu_valid_o,
    output logic                     fpu_valid_o,
    output logic                     branch_pending_o
);
    localparam logic [2:0] FU_NONE  = 3'd0;
    localparam logic [2:0] FU_LOAD  = 3'd1;
    localparam logic [2:0] FU_STORE = 3'd2;
    localparam logic [2:0] FU_ALU   = 3'd3;
    localparam logic [2:0] FU_CTRL  = 3'd4;
    localparam logic [2:0] FU_MULT  = 3'd5;
    localparam logic [2:0] FU_CSR   = 3'd6;
    localparam logic [2:0] FU_FPU   = 3'd7;

    logic                     w_unit_ok;
    logic                     w_hazard;
    logic                     w_is_flu_wb;
    logic [7:0]               r_op;
    logic [XLEN-1:0]          r_a;
    logic [XLEN-1:0]          r_b;
    logic [XLEN-1:0]          r_imm;
    logic [TRANS_ID_BITS-1:0] r_id;
    logic                     r_alu;
    logic                     r_branch;
    logic                     r_csr;
    logic                     r_mult;
    logic                     r_lsu;
    logic                     r_fpu;
    logic                     r_branch_pending;

    always_comb begin
        w_unit_ok   = (issue_fu_i == FU_LOAD || issue_fu_i == FU_STORE) ? lsu_ready_i :
                      (issue_fu_i == FU_FPU)  ? fpu_ready_i :
                      (issue_fu_i == FU_NONE) ? 1'b1 : flu_ready_i;
        // MULT results land on the shared FLU writeback port a cycle later
        w_is_flu_wb = issue_fu_i == FU_ALU || issue_fu_i == FU_CTRL || issue_fu_i == FU_CSR;
        w_hazard    = (w_is_flu_wb && r_mult) || (issue_fu_i == FU_CTRL && r_branch_pending);
        issue_ack_o = rst_ni && issue_valid_i && !flush_i && w_unit_ok && !w_hazard;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op             <= '0;
            r_a              <= '0;
            r_b              <= '0;
            r_imm            <= '0;
            r_id             <= '0;
            r_alu            <= 1'b0;
            r_branch         <= 1'b0;
            r_csr            <= 1'b0;
            r_mult           <= 1'b0;
            r_lsu            <= 1'b0;
            r_fpu            <= 1'b0;
            r_branch_pending <= 1'b0;
        end else begin
            if (issue_ack_o) begin
                r_op  <= issue_op_i;
                r_a   <= issue_operand_a_i;
                r_b   <= issue_operand_b_i;
                r_imm <= issue_imm_i;
                r_id  <= issue_trans_id_i;
            end
            r_alu            <= issue_ack_o && issue_fu_i == FU_ALU;
            r_branch         <= issue_ack_o && issue_fu_i == FU_CTRL;
            r_csr            <= issue_ack_o && issue_fu_i == FU_CSR;
            r_mult           <= issue_ack_o && issue_fu_i == FU_MULT;
            r_lsu            <= issue_ack_o && (issue_fu_i == FU_LOAD || issue_fu_i == FU_STORE);
            r_fpu            <= issue_ack_o && issue_fu_i == FU_FPU;
            r_branch_pending <= (flush_i || resolve_branch_i) ? 1'b0 :
                                (issue_ack_o && issue_fu_i == FU_CTRL) ? 1'b1 : r_branch_pending;
        end
    end

    assign fu_op_o          = r_op;
    assign operand_a_o      = r_a;
    assign operand_b_o      = r_b;
    assign imm_o            = r_imm;
    assign trans_id_o       = r_id;
    assign alu_valid_o      = r_alu;
    assign branch_valid_o   = r_branch;
    assign csr_valid_o      = r_csr;
    assign mult_valid_o     = r_mult;
    assign lsu_valid_o      = r_lsu;
    assign fpu_valid_o      = r_fpu;
    assign branch_pending_o = r_branch_pending;
endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb_fu_issue_ctrl: directed-vector bench for fu_issue_ctrl
module tb_fu_issue_ctrl;
    localparam int TB_ID = 3;
    localparam int TB_XLEN = 64;
    localparam logic [2:0] NONE = 3'd0, STORE = 3'd2, ALU = 3'd3, CTRL = 3'd4, MULT = 3'd5, CSR = 3'd6, FPU = 3'd7;
    localparam logic [5:0] S_ALU = 6'b100000, S_BR = 6'b010000, S_MUL = 6'b000100, S_LSU = 6'b000010, S_FPU = 6'b000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic valid = 1'b0;
    logic ack;
    logic [2:0] fu = 3'd0;
    logic [7:0] op = 8'd0;
    logic [TB_XLEN-1:0] a = '0, b = '0, imm = '0;
    logic [TB_ID-1:0] id = '0;
    logic flu_rdy = 1'b1, lsu_rdy = 1'b1, fpu_rdy = 1'b1, resolve = 1'b0;
    logic [7:0] op_o;
    logic [TB_XLEN-1:0] a_o, b_o, imm_o;
    logic [TB_ID-1:0] id_o;
    logic alu_v, br_v, csr_v, mul_v, lsu_v, fpu_v, pend;
    logic [5:0] strobes;
    int checks = 0;
    int errors = 0;

    assign strobes = {alu_v, br_v, csr_v, mul_v, lsu_v, fpu_v};

    fu_issue_ctrl #(.TRANS_ID_BITS(TB_ID), .XLEN(TB_XLEN)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .issue_valid_i(valid), .issue_ack_o(ack),
        .issue_fu_i(fu), .issue_op_i(op), .issue_operand_a_i(a), .issue_operand_b_i(b),
        .issue_imm_i(imm), .issue_trans_id_i(id), .flu_ready_i(flu_rdy), .lsu_ready_i(lsu_rdy),
        .fpu_ready_i(fpu_rdy), .resolve_branch_i(resolve), .fu_op_o(op_o), .operand_a_o(a_o),
        .operand_b_o(b_o), .imm_o(imm_o), .trans_id_o(id_o), .alu_valid_o(alu_v),
        .branch_valid_o(br_v), .csr_valid_o(csr_v), .mult_valid_o(mul_v), .lsu_valid_o(lsu_v),
        .fpu_valid_o(fpu_v), .branch_pending_o(pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] f, input logic [TB_ID-1:0] t);
        valid = 1'b1;
        fu = f;
        id = t;
        op = {5'd0, f};
        a = {32'h0, 29'd0, t} + 64'h100;
        b = {32'h0, 29'd0, t} + 64'h200;
        imm = {32'h0, 29'd0, t} + 64'h300;
        #1;
    endtask

    task automatic idle();
        valid = 1'b0;
        fu = NONE;
        #1;
    endtask

    task automatic test_reset();
        #3;
        offer(ALU, 3'd1);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", ack); end
        checks++; if (strobes !== 6'd0) begin errors++; $display("FAIL reset_strobes: got %b exp 000000", strobes); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0", pend); end
        checks++; if ({op_o, a_o, b_o, imm_o, id_o} !== '0) begin errors++; $display("FAIL reset_bundle: got %h/%h/%h/%h/%h exp 0", op_o, a_o, b_o, imm_o, id_o); end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            offer(ALU, i[TB_ID-1:0]);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b exp 1", i, ack); end
            tick();
            checks++; if (strobes !== S_ALU || id_o !== i[TB_ID-1:0]) begin errors++; $display("FAIL b2b_out%0d: strobes %b id %0d exp %b id %0d", i, strobes, id_o, S_ALU, i); end
        end
        idle();
        tick();
        checks++; if (strobes !== 6'd0 || id_o !== 3'd3 || a_o !== 64'h103) begin errors++; $display("FAIL b2b_hold: strobes %b id %0d a %h exp 0 id 3 a 103", strobes, id_o, a_o); end
    endtask

    task automatic test_mult();
        offer(MULT, 3'd4);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mult_ack: got %b exp 1", ack); end
        tick();
        checks++; if (strobes !== S_MUL || id_o !== 3'd4) begin errors++; $display("FAIL mult_strobe: got %b id %0d exp %b id 4", strobes, id_o, S_MUL); end
        offer(ALU, 3'd5);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mult_alu_block: got %b exp 0", ack); end
        tick();
        checks++; if (strobes !== 6'd0 || ack !== 1'b1) begin errors++; $display("FAIL mult_alu_retry: strobes %b ack %b exp 0/1", strobes, ack); end
        tick();
        checks++; if (strobes !== S_ALU || id_o !== 3'd5) begin errors++; $display("FAIL mult_alu_out: got %b id %0d exp %b id 5", strobes, id_o, S_ALU); end
        offer(MULT, 3'd6);
        tick();
        offer(MULT, 3'd7);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mult_mult_ack: got %b exp 1", ack); end
        tick();
        checks++; if (strobes !== S_MUL || id_o !== 3'd7) begin errors++; $display("FAIL mult_mult_out: got %b id %0d exp %b id 7", strobes, id_o, S_MUL); end
        offer(CSR, 3'd1);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mult_csr_block: got %b exp 0", ack); end
        idle();
        tick();
    endtask

    task automatic test_branch();
        offer(CTRL, 3'd1);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL br_ack1: got %b exp 1", ack); end
        tick();
        checks++; if (strobes !== S_BR || pend !== 1'b1) begin errors++; $display("FAIL br_issue: strobes %b pend %b exp %b/1", strobes, pend, S_BR); end
        resolve = 1'b1;
        offer(CTRL, 3'd2);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL br_block: got %b exp 0", ack); end
        tick();
        resolve = 1'b0;
        #1;
        checks++; if (pend !== 1'b0 || ack !== 1'b1) begin errors++; $display("FAIL br_resolve: pend %b ack %b exp 0/1", pend, ack); end
        tick();
        checks++; if (strobes !== S_BR || id_o !== 3'd2 || pend !== 1'b1) begin errors++; $display("FAIL br_second: strobes %b id %0d pend %b exp %b/2/1", strobes, id_o, pend, S_BR); end
        idle();
        resolve = 1'b1;
        tick();
        resolve = 1'b0;
        checks++; if (pend !== 1'b0 || strobes !== 6'd0) begin errors++; $display("FAIL br_clear: pend %b strobes %b exp 0/0", pend, strobes); end
    endtask

    task automatic test_lsu_stall();
        lsu_rdy = 1'b0;
        offer(STORE, 3'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (ack !== 1'b0) begin errors++; $display("FAIL lsu_stall%0d: ack %b exp 0", i, ack); end
            tick();
            checks++; if (strobes !== 6'd0) begin errors++; $display("FAIL lsu_stall_strobe%0d: got %b exp 0", i, strobes); end
        end
        lsu_rdy = 1'b1;
        #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL lsu_ack: got %b exp 1", ack); end
        tick();
        lsu_rdy = 1'b0;
        idle();
        checks++; if (strobes !== S_LSU || op_o !== 8'd2 || a_o !== 64'h103 || b_o !== 64'h203 || imm_o !== 64'h303 || id_o !== 3'd3) begin
            errors++; $display("FAIL lsu_out: strobes %b op %h a %h b %h imm %h id %0d exp %b 02 103 203 303 3", strobes, op_o, a_o, b_o, imm_o, id_o, S_LSU);
        end
        lsu_rdy = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        offer(CTRL, 3'd2);
        tick();
        offer(ALU, 3'd4);
        flush = 1'b1;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL flush_ack: got %b exp 0", ack); end
        tick();
        flush = 1'b0;
        checks++; if (strobes !== 6'd0 || pend !== 1'b0 || id_o !== 3'd2) begin errors++; $display("FAIL flush_state: strobes %b pend %b id %0d exp 0/0/2", strobes, pend, id_o); end
        offer(CTRL, 3'd5);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL flush_newbr: got %b exp 1", ack); end
        tick();
        idle();
        resolve = 1'b1;
        tick();
        resolve = 1'b0;
    endtask

    task automatic test_none_fpu();
        flu_rdy = 1'b0;
        lsu_rdy = 1'b0;
        fpu_rdy = 1'b0;
        offer(NONE, 3'd6);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL none_ack: got %b exp 1", ack); end
        tick();
        checks++; if (strobes !== 6'd0 || id_o !== 3'd6) begin errors++; $display("FAIL none_out: strobes %b id %0d exp 0/6", strobes, id_o); end
        offer(FPU, 3'd7);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL fpu_block: got %b exp 0", ack); end
        fpu_rdy = 1'b1;
        #1;
        tick();
        checks++; if (strobes !== S_FPU || id_o !== 3'd7) begin errors++; $display("FAIL fpu_out: strobes %b id %0d exp %b/7", strobes, id_o, S_FPU); end
        flu_rdy = 1'b1;
        lsu_rdy = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        offer(ALU, 3'd5);
        tick();
        checks++; if (alu_v !== 1'b1) begin errors++; $display("FAIL areset_pre: alu %b exp 1", alu_v); end
        rst_n = 1'b0;
        #1;
        checks++; if (strobes !== 6'd0 || pend !== 1'b0 || {op_o, a_o, b_o, imm_o, id_o} !== '0 || ack !== 1'b0) begin
            errors++; $display("FAIL areset: strobes %b pend %b id %0d a %h ack %b exp all 0", strobes, pend, id_o, a_o, ack);
        end
        idle();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mult();
        test_branch();
        test_lsu_stall();
        test_flush();
        test_none_fpu();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
